// File: rtl/rv_alu_pkg.sv
// Shared definitions for the arbitrated RV32 R-type ALU: opcode/funct3 encodings,
// ALU operation enum, response-buffer states and the request decoder.
package rv_alu_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_ILLEGAL
    } alu_op_e;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_e;

    // funct7b5 only selects SUB within ADD/SUB; AND/OR ignore it.
    function automatic alu_op_e alu_decode(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic       f7b5
    );
        alu_op_e op;
        op = ALU_ILLEGAL;
        if (opcode == OPC_OP) begin
            case (funct3)
                F3_ADDSUB: op = f7b5 ? ALU_SUB : ALU_ADD;
                F3_AND:    op = ALU_AND;
                F3_OR:     op = ALU_OR;
                default:   op = ALU_ILLEGAL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/rv_alu_arbiter_rr.sv
// Round-robin arbiter: searches from r_ptr upward (mod N) for the first request;
// the pointer moves past the granted requester whenever the grant is consumed.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned W = $clog2(N);

    logic [W-1:0] r_ptr;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_kidx;
    logic [N-1:0] w_grant;
    logic         w_found;
    int unsigned  w_k;

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        w_kidx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_k    = (32'(r_ptr) + i) % N;
            w_kidx = W'(w_k);
            if (!w_found && req[w_kidx]) begin
                w_found        = 1'b1;
                w_grant[w_kidx] = 1'b1;
                w_idx          = w_kidx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign grant     = w_grant;
    assign grant_idx = w_idx;

endmodule

// File: rtl/rv_alu_arbiter.sv
// Shared RV32 ADD/SUB/AND/OR unit: round-robin picks one requester per cycle and
// the result lands in a single-entry response buffer that refills while draining.
module rv_alu_arbiter
    import rv_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ),
    parameter int unsigned CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*7-1:0]    req_opcode,
    input  logic [NREQ*3-1:0]    req_funct3,
    input  logic [NREQ-1:0]      req_funct7b5,
    input  logic [NREQ*XLEN-1:0] req_rs1,
    input  logic [NREQ*XLEN-1:0] req_rs2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic [CNTW-1:0]      illegal_cnt
);

    buf_state_e      r_state;
    buf_state_e      w_state_nxt;
    logic [XLEN-1:0] r_data;
    logic [IDW-1:0]  r_id;
    logic            r_err;
    logic [CNTW-1:0] r_illegal_cnt;

    logic            w_can_accept;
    logic            w_accept;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_f7b5;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    alu_op_e         w_op;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (w_accept),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_can_accept = (r_state == BUF_EMPTY) | rsp_ready;
    assign w_accept     = (|req_valid) & w_can_accept;
    assign req_ready    = w_grant & {NREQ{w_can_accept}};

    // One-hot grant selects the operand fields of the winning requester.
    always_comb begin
        w_opcode = '0;
        w_funct3 = '0;
        w_f7b5   = 1'b0;
        w_rs1    = '0;
        w_rs2    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_opcode = req_opcode[k*7 +: 7];
                w_funct3 = req_funct3[k*3 +: 3];
                w_f7b5   = req_funct7b5[k];
                w_rs1    = req_rs1[k*XLEN +: XLEN];
                w_rs2    = req_rs2[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_op      = alu_decode(w_opcode, w_funct3, w_f7b5);
        w_result  = '0;
        w_illegal = 1'b0;
        case (w_op)
            ALU_ADD: w_result = w_rs1 + w_rs2;
            ALU_SUB: w_result = w_rs1 - w_rs2;
            ALU_AND: w_result = w_rs1 & w_rs2;
            ALU_OR:  w_result = w_rs1 | w_rs2;
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUF_EMPTY: if (w_accept) w_state_nxt = BUF_FULL;
            BUF_FULL: begin
                if (w_accept)       w_state_nxt = BUF_FULL;
                else if (rsp_ready) w_state_nxt = BUF_EMPTY;
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BUF_EMPTY;
            r_data        <= '0;
            r_id          <= '0;
            r_err         <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= w_result;
                r_id   <= w_grant_idx;
                r_err  <= w_illegal;
                if (w_illegal && (r_illegal_cnt != '1)) begin
                    r_illegal_cnt <= r_illegal_cnt + 1'b1;
                end
            end
        end
    end

    assign rsp_valid   = (r_state == BUF_FULL);
    assign rsp_data    = r_data;
    assign rsp_id      = r_id;
    assign rsp_err     = r_err;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Bench for rv_alu_arbiter: a 2-requester instance tracked by a scoreboard model,
// plus a 4-requester instance with a 4-bit counter for rotation and saturation.
module tb_rv_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [13:0] req_opcode = '0;
    logic [5:0]  req_funct3 = '0;
    logic [1:0]  req_funct7b5 = '0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [0:0]  rsp_id;
    logic        rsp_err;
    logic [15:0] illegal_cnt;

    logic [3:0]   b_req_valid = '0;
    logic [3:0]   b_req_ready;
    logic [27:0]  b_req_opcode = '0;
    logic [11:0]  b_req_funct3 = '0;
    logic [3:0]   b_req_funct7b5 = '0;
    logic [127:0] b_req_rs1 = '0;
    logic [127:0] b_req_rs2 = '0;
    logic         b_rsp_valid;
    logic         b_rsp_ready = 1'b0;
    logic [31:0]  b_rsp_data;
    logic [1:0]   b_rsp_id;
    logic         b_rsp_err;
    logic [3:0]   b_illegal_cnt;

    int total = 0;
    int bad   = 0;

    rv_alu_arbiter #(.XLEN(32), .NREQ(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .illegal_cnt(illegal_cnt)
    );

    rv_alu_arbiter #(.XLEN(32), .NREQ(4), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_opcode(b_req_opcode), .req_funct3(b_req_funct3), .req_funct7b5(b_req_funct7b5),
        .req_rs1(b_req_rs1), .req_rs2(b_req_rs2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_id(b_rsp_id), .rsp_err(b_rsp_err), .illegal_cnt(b_illegal_cnt)
    );

    always #5 clk = ~clk;

    // Reference model of the 2-requester instance; expected responses queue at accept time.
    typedef struct {
        logic [31:0] data;
        logic        id;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    rsp_t        m_r;
    int unsigned m_ptr = 0;
    int unsigned m_k;
    int unsigned m_g;
    logic        m_valid = 1'b0;
    logic        m_found;
    logic        m_can;
    logic [1:0]  m_exp;
    logic [15:0] m_cnt = '0;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [31:0] m_a;
    logic [31:0] m_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_cnt   = '0;
            sb.delete();
        end else begin
            m_found = 1'b0;
            m_g     = 0;
            for (int i = 0; i < 2; i++) begin
                m_k = (m_ptr + i) % 2;
                if (!m_found && req_valid[m_k]) begin
                    m_found = 1'b1;
                    m_g     = m_k;
                end
            end
            m_can = !m_valid || rsp_ready;
            m_exp = 2'b00;
            if (m_found && m_can) m_exp[m_g] = 1'b1;
            total++;
            if (req_ready !== m_exp) begin
                bad++;
                $display("FAIL sb_req_ready got=%b exp=%b t=%0t", req_ready, m_exp, $time);
            end
            total++;
            if (rsp_valid !== m_valid) begin
                bad++;
                $display("FAIL sb_rsp_valid got=%b exp=%b t=%0t", rsp_valid, m_valid, $time);
            end
            total++;
            if (illegal_cnt !== m_cnt) begin
                bad++;
                $display("FAIL sb_illegal_cnt got=%0d exp=%0d t=%0t", illegal_cnt, m_cnt, $time);
            end
            if (m_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow got=empty exp=entry t=%0t", $time);
                end else begin
                    m_r = sb[0];
                    if (rsp_data !== m_r.data || rsp_id !== m_r.id || rsp_err !== m_r.err) begin
                        bad++;
                        $display("FAIL sb_rsp got=%h/%0d/%b exp=%h/%0d/%b t=%0t",
                                 rsp_data, rsp_id, rsp_err, m_r.data, m_r.id, m_r.err, $time);
                    end
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            if (m_found && m_can) begin
                m_opc    = req_opcode[m_g*7 +: 7];
                m_f3     = req_funct3[m_g*3 +: 3];
                m_f7     = req_funct7b5[m_g];
                m_a      = req_rs1[m_g*32 +: 32];
                m_b      = req_rs2[m_g*32 +: 32];
                m_r.id   = m_g[0];
                m_r.err  = 1'b0;
                m_r.data = 32'h0;
                if (m_opc == 7'h33 && m_f3 == 3'b000)      m_r.data = m_f7 ? (m_a - m_b) : (m_a + m_b);
                else if (m_opc == 7'h33 && m_f3 == 3'b111) m_r.data = m_a & m_b;
                else if (m_opc == 7'h33 && m_f3 == 3'b110) m_r.data = m_a | m_b;
                else                                       m_r.err  = 1'b1;
                sb.push_back(m_r);
                if (m_r.err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_ptr   = (m_g + 1) % 2;
                m_valid = 1'b1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [6:0] opc, input logic [2:0] f3,
                           input logic f7, input logic [31:0] a, input logic [31:0] b);
        req_opcode[k*7 +: 7]  = opc;
        req_funct3[k*3 +: 3]  = f3;
        req_funct7b5[k]       = f7;
        req_rs1[k*32 +: 32]   = a;
        req_rs2[k*32 +: 32]   = b;
    endtask

    task automatic b_set_req(input int k, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
        b_req_opcode[k*7 +: 7] = opc;
        b_req_funct3[k*3 +: 3] = f3;
        b_req_funct7b5[k]      = 1'b0;
        b_req_rs1[k*32 +: 32]  = a;
        b_req_rs2[k*32 +: 32]  = b;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        b_req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0 ||
            illegal_cnt !== 16'h0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h/%0d/%b/%0d/%b exp=0/0/0/0/0/00",
                     rsp_valid, rsp_data, rsp_id, rsp_err, illegal_cnt, req_ready);
        end
        tick();
        set_req(0, 7'h33, 3'b000, 1'b0, 32'd1, 32'd1);
        set_req(1, 7'h33, 3'b000, 1'b0, 32'd2, 32'd2);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_ptr_grant got=%b exp=01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_add_sub();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 7'h33, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL add_wrap got=%b/%h/%0d/%b exp=1/00000000/0/0", rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        tick();
        set_req(0, 7'h33, 3'b000, 1'b1, 32'h0, 32'h1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow got=%b/%h/%b exp=1/ffffffff/0", rsp_valid, rsp_data, rsp_err);
        end
        tick();
    endtask

    task automatic test_rotation();
        logic [1:0]  exp_rdy;
        logic        exp_id;
        logic [31:0] exp_data;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 7'h33, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        set_req(1, 7'h33, 3'b110, 1'b1, 32'h0000_000F, 32'h0000_00F0);
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                total++;
                if (req_ready !== exp_rdy) begin
                    bad++;
                    $display("FAIL rotation_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
                end
            end
            if (c > 0) begin
                exp_id   = ((c - 1) % 2 == 1);
                exp_data = exp_id ? 32'h0000_00FF : 32'hF000_F000;
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin
                    bad++;
                    $display("FAIL rotation_rsp c=%0d got=%b/%0d/%h exp=1/%0d/%h",
                             c, rsp_valid, rsp_id, rsp_data, exp_id, exp_data);
                end
            end
            tick();
            if (c == 3) req_valid = 2'b00;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 7'h33, 3'b000, 1'b0, 32'd5, 32'd3);
        set_req(1, 7'h33, 3'b000, 1'b1, 32'd10, 32'd4);
        req_valid = 2'b11;
        @(negedge clk);
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL bp_first_grant got=%b exp=01", req_ready);
        end
        tick();
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_id !== 1'b0 ||
                rsp_err !== 1'b0 || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL bp_hold s=%0d got=%b/%h/%0d/%b/%b exp=1/00000008/0/0/00",
                         s, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 2'b10 || rsp_data !== 32'd8) begin
            bad++;
            $display("FAIL bp_drain_refill got=%b/%h exp=10/00000008", req_ready, rsp_data);
        end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd6 || rsp_id !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_bubble got=%b/%h/%0d exp=1/00000006/1", rsp_valid, rsp_data, rsp_id);
        end
        tick();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 7'h13, 3'b000, 1'b0, 32'd7, 32'd9);
        req_valid = 2'b01;
        tick();
        set_req(0, 7'h33, 3'b001, 1'b0, 32'd7, 32'd9);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_opcode got=%b/%h/%b exp=1/00000000/1", rsp_valid, rsp_data, rsp_err);
        end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if (rsp_data !== 32'h0 || rsp_err !== 1'b1 || illegal_cnt !== 16'd2) begin
            bad++;
            $display("FAIL illegal_funct3 got=%h/%b/%0d exp=00000000/1/2", rsp_data, rsp_err, illegal_cnt);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 7'h33, 3'b000, 1'b0, 32'd1, 32'd2);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd3) begin
            bad++;
            $display("FAIL areset_pre got=%b/%h exp=1/00000003", rsp_valid, rsp_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL areset_immediate got=%b/%h exp=0/00000000", rsp_valid, rsp_data);
        end
        @(negedge clk);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
    endtask

    task automatic test_nreq4_order();
        int unsigned ord1[4] = '{2, 3, 0, 1};
        int unsigned ord2[3] = '{2, 0, 1};
        logic [3:0]  exp_rdy;
        do_reset();
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) b_set_req(k, 7'h33, 3'b000, 32'(k), 32'd100);
        b_req_valid = 4'b0010;
        tick();
        b_req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                exp_rdy = 4'b0001 << ord1[c];
                total++;
                if (b_req_ready !== exp_rdy) begin
                    bad++;
                    $display("FAIL n4_all_grant c=%0d got=%b exp=%b", c, b_req_ready, exp_rdy);
                end
            end
            if (c > 0) begin
                total++;
                if (b_rsp_valid !== 1'b1 || b_rsp_id !== 2'(ord1[c-1]) || b_rsp_data !== ord1[c-1] + 100) begin
                    bad++;
                    $display("FAIL n4_all_rsp c=%0d got=%0d/%0d exp=%0d/%0d",
                             c, b_rsp_id, b_rsp_data, ord1[c-1], ord1[c-1] + 100);
                end
            end
            tick();
            if (c == 3) b_req_valid = 4'b0000;
        end
        b_req_valid = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) begin
                exp_rdy = 4'b0001 << ord2[c];
                total++;
                if (b_req_ready !== exp_rdy) begin
                    bad++;
                    $display("FAIL n4_drop3_grant c=%0d got=%b exp=%b", c, b_req_ready, exp_rdy);
                end
            end
            if (c > 0) begin
                total++;
                if (b_rsp_id !== 2'(ord2[c-1]) || b_rsp_data !== ord2[c-1] + 100) begin
                    bad++;
                    $display("FAIL n4_drop3_rsp c=%0d got=%0d/%0d exp=%0d/%0d",
                             c, b_rsp_id, b_rsp_data, ord2[c-1], ord2[c-1] + 100);
                end
            end
            tick();
            if (c == 2) b_req_valid = 4'b0000;
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        do_reset();
        b_rsp_ready = 1'b1;
        b_set_req(0, 7'h13, 3'b000, 32'd1, 32'd1);
        b_req_valid = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            total++;
            if (b_illegal_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, b_illegal_cnt, exp_cnt);
            end
            tick();
        end
        b_req_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (b_rsp_err !== 1'b1 || b_rsp_data !== 32'h0 || b_illegal_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_final got=%b/%h/%0d exp=1/00000000/15", b_rsp_err, b_rsp_data, b_illegal_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_rotation();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        test_nreq4_order();
        test_saturation();
        rsp_ready = 1'b1;
        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
